// File: rtl/cnn_layer_accel_quad_job_ctrl_if.sv
// Host-facing job/result handshake bundle for one CNN layer accelerator quad.
//   master : host side (drives job requests, acks and result handshakes)
//   slave  : job controller side (drives accept/request/complete, latched
//            parameters, output position and the error flag)
// job_parameters layout: [15:0] rows, [31:16] cols, [47:32] depth,
// [127:48] passthrough.
interface cnn_layer_accel_quad_job_ctrl_if #(
  parameter int C_DIM_WIDTH = 16
);
  logic                   job_start;
  logic                   job_accept;
  logic [127:0]           job_parameters;
  logic                   job_parameters_valid;
  logic                   job_fetch_request;
  logic                   job_fetch_ack;
  logic                   job_fetch_complete;
  logic                   job_complete;
  logic                   job_complete_ack;
  logic                   result_valid;
  logic                   result_accept;
  logic                   compute_en;
  logic [C_DIM_WIDTH-1:0] param_rows;
  logic [C_DIM_WIDTH-1:0] param_cols;
  logic [C_DIM_WIDTH-1:0] param_depth;
  logic [79:0]            param_extra;
  logic [31:0]            output_row;
  logic [31:0]            output_col;
  logic [31:0]            output_depth;
  logic                   err_unexpected_result;

  modport master (
    output job_start, job_parameters, job_parameters_valid,
           job_fetch_ack, job_fetch_complete, job_complete_ack,
           result_valid, result_accept,
    input  job_accept, job_fetch_request, job_complete, compute_en,
           param_rows, param_cols, param_depth, param_extra,
           output_row, output_col, output_depth, err_unexpected_result
  );

  modport slave (
    input  job_start, job_parameters, job_parameters_valid,
           job_fetch_ack, job_fetch_complete, job_complete_ack,
           result_valid, result_accept,
    output job_accept, job_fetch_request, job_complete, compute_en,
           param_rows, param_cols, param_depth, param_extra,
           output_row, output_col, output_depth, err_unexpected_result
  );
endinterface

// File: rtl/cnn_layer_accel_quad_job_ctrl.sv
// Job controller for one CNN layer accelerator quad.
// Accepts a host job, latches its parameters, requests and waits out the
// weight/pixel fetch, enables compute, tracks the (row, col, depth) position
// of each accepted result and raises job completion after the last one.
// Ports:
//   clk_if : interface clock, all logic on its rising edge
//   rst_n  : synchronous active-low reset
//   bus    : job/result handshake bundle (slave modport)
// All outputs are registered.
module cnn_layer_accel_quad_job_ctrl #(
  parameter int C_DIM_WIDTH = 16
) (
  input  logic                          clk_if,
  input  logic                          rst_n,
  cnn_layer_accel_quad_job_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARAM,
    ST_FETCH_REQ,
    ST_FETCH,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [C_DIM_WIDTH-1:0] DIM_ONE  = {{(C_DIM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_DIM_WIDTH-1:0] DIM_ZERO = '0;

  state_t                 state_q, state_d;
  logic                   accept_q, accept_d;
  logic                   fetch_req_q, fetch_req_d;
  logic                   complete_q, complete_d;
  logic                   compute_en_q, compute_en_d;
  logic                   err_q, err_d;
  logic [C_DIM_WIDTH-1:0] rows_q, rows_d;
  logic [C_DIM_WIDTH-1:0] cols_q, cols_d;
  logic [C_DIM_WIDTH-1:0] depth_q, depth_d;
  logic [79:0]            extra_q, extra_d;
  logic [C_DIM_WIDTH-1:0] row_q, row_d;
  logic [C_DIM_WIDTH-1:0] col_q, col_d;
  logic [C_DIM_WIDTH-1:0] dep_q, dep_d;

  logic handshake;
  logic capture;
  logic zero_dim;

  assign handshake = bus.result_valid & bus.result_accept;
  assign zero_dim  = (rows_q == DIM_ZERO) || (cols_q == DIM_ZERO) || (depth_q == DIM_ZERO);

  always_comb begin
    state_d  = state_q;
    accept_d = 1'b0;
    err_d    = err_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    depth_d  = depth_q;
    extra_d  = extra_q;
    row_d    = row_q;
    col_d    = col_q;
    dep_d    = dep_q;
    capture  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.job_start) begin
          accept_d = 1'b1;
          err_d    = 1'b0;
          // Parameters presented together with the start skip PARAM.
          if (bus.job_parameters_valid) begin
            capture = 1'b1;
            state_d = ST_FETCH_REQ;
          end else begin
            state_d = ST_PARAM;
          end
        end
      end
      ST_PARAM: begin
        if (bus.job_parameters_valid) begin
          capture = 1'b1;
          state_d = ST_FETCH_REQ;
        end
      end
      ST_FETCH_REQ: begin
        // A fetch_complete arriving with the ack is ignored on purpose;
        // the host must repeat it once FETCH is reached.
        if (bus.job_fetch_ack) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.job_fetch_complete) begin
          state_d = zero_dim ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Position walks col fastest, then row, then depth.
        if (handshake) begin
          if (col_q == cols_q - DIM_ONE) begin
            col_d = DIM_ZERO;
            if (row_q == rows_q - DIM_ONE) begin
              row_d = DIM_ZERO;
              if (dep_q == depth_q - DIM_ONE) begin
                dep_d   = DIM_ZERO;
                state_d = ST_DONE;
              end else begin
                dep_d = dep_q + DIM_ONE;
              end
            end else begin
              row_d = row_q + DIM_ONE;
            end
          end else begin
            col_d = col_q + DIM_ONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.job_complete_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      rows_d  = bus.job_parameters[C_DIM_WIDTH-1:0];
      cols_d  = bus.job_parameters[16 +: C_DIM_WIDTH];
      depth_d = bus.job_parameters[32 +: C_DIM_WIDTH];
      extra_d = bus.job_parameters[127:48];
      row_d   = DIM_ZERO;
      col_d   = DIM_ZERO;
      dep_d   = DIM_ZERO;
    end

    // A stray result handshake wins over the clear done by job_start.
    if (handshake && (state_q != ST_RUN)) begin
      err_d = 1'b1;
    end

    // Registered outputs follow the state being entered.
    fetch_req_d  = (state_d == ST_FETCH_REQ);
    compute_en_d = (state_d == ST_RUN);
    complete_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_if) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      accept_q     <= 1'b0;
      fetch_req_q  <= 1'b0;
      complete_q   <= 1'b0;
      compute_en_q <= 1'b0;
      err_q        <= 1'b0;
      rows_q       <= '0;
      cols_q       <= '0;
      depth_q      <= '0;
      extra_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      dep_q        <= '0;
    end else begin
      state_q      <= state_d;
      accept_q     <= accept_d;
      fetch_req_q  <= fetch_req_d;
      complete_q   <= complete_d;
      compute_en_q <= compute_en_d;
      err_q        <= err_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      depth_q      <= depth_d;
      extra_q      <= extra_d;
      row_q        <= row_d;
      col_q        <= col_d;
      dep_q        <= dep_d;
    end
  end

  assign bus.job_accept            = accept_q;
  assign bus.job_fetch_request     = fetch_req_q;
  assign bus.job_complete          = complete_q;
  assign bus.compute_en            = compute_en_q;
  assign bus.err_unexpected_result = err_q;
  assign bus.param_rows            = rows_q;
  assign bus.param_cols            = cols_q;
  assign bus.param_depth           = depth_q;
  assign bus.param_extra           = extra_q;
  assign bus.output_row            = {{(32-C_DIM_WIDTH){1'b0}}, row_q};
  assign bus.output_col            = {{(32-C_DIM_WIDTH){1'b0}}, col_q};
  assign bus.output_depth          = {{(32-C_DIM_WIDTH){1'b0}}, dep_q};

endmodule

// File: doc/cnn_layer_accel_quad_job_ctrl.md
# cnn_layer_accel_quad_job_ctrl

Interface-side job controller for one CNN layer accelerator quad. It answers the host job handshake: accepts the job, latches the parameters, requests and waits out the fetch phase, and enables compute. It then tracks the output position of every accepted result and raises job completion after the last result. It sits between the host job/result ports of the quad and the quad datapath.

## Interface
- C_DIM_WIDTH, 16, width of each dimension field in job_parameters.
- clk_if  in  1  interface clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- job_start  in  1  host requests a new job.
- job_accept  out  1  one-cycle pulse acknowledging job_start.
- job_parameters  in  128  [15:0] rows, [31:16] cols, [47:32] depth, [127:48] passthrough.
- job_parameters_valid  in  1  job_parameters is valid this cycle.
- job_fetch_request  out  1  held high until job_fetch_ack.
- job_fetch_ack  in  1  host acknowledges the fetch request.
- job_fetch_complete  in  1  host signals that weights and pixels are fully delivered.
- job_complete  out  1  held high until job_complete_ack.
- job_complete_ack  in  1  host acknowledges completion.
- result_valid  in  1  datapath result valid.
- result_accept  in  1  host accepts the result.
- compute_en  out  1  datapath enable; high only in RUN.
- param_rows, param_cols, param_depth  out  C_DIM_WIDTH each  latched dimensions.
- param_extra  out  80  latched job_parameters[127:48].
- output_row, output_col, output_depth  out  32 each  position of the next result to be accepted.
- err_unexpected_result  out  1  sticky; set when a result handshake occurs outside RUN.

## Operation
- States: IDLE, PARAM, FETCH_REQ, FETCH, RUN, DONE.
- IDLE, job_start=1:
  - job_accept is registered high for the next cycle only.
  - err_unexpected_result clears.
  - If job_parameters_valid is also high, parameters latch and the state goes to FETCH_REQ; otherwise it goes to PARAM.
- PARAM: on job_parameters_valid, latch all fields and go to FETCH_REQ.
- FETCH_REQ: job_fetch_request=1. When job_fetch_ack is sampled high, drop the request next cycle and go to FETCH.
- FETCH: when job_fetch_complete is sampled high:
  - If any dimension is 0, go to DONE (zero-size job, no results expected).
  - Otherwise go to RUN.
- RUN: compute_en=1. A handshake is result_valid && result_accept in the same cycle. On each handshake the position counters advance:
  - output_col increments.
  - When output_col = cols-1, it wraps to 0 and output_row increments.
  - When output_row = rows-1 and it wraps, it goes to 0 and output_depth increments.
  - result_valid without result_accept does not advance the counters.
- Last handshake (col=cols-1, row=rows-1, depth=depth-1): all counters return to 0 and the state goes to DONE.
- DONE: job_complete=1. When job_complete_ack is sampled high, go to IDLE and drop job_complete next cycle.
- A handshake in any state other than RUN sets err_unexpected_result and does not move the counters.
- job_start outside IDLE is ignored, and no job_accept is issued.
- Latched param_* hold until the next parameter capture.
- Counter arithmetic is unsigned C_DIM_WIDTH compares, zero-extended onto 32-bit outputs.

## Timing
- Reset (rst_n=0 at a clock edge): state IDLE. Every output resets to 0: job_accept, job_fetch_request, job_complete, compute_en, all param_*, all output_*, err_unexpected_result. Reset mid-job aborts the job with no completion.
- All outputs are registered. Each state transition takes effect one cycle after its qualifying input is sampled.
- job_start sampled at cycle N gives job_accept=1 at N+1 only.
- job_fetch_ack sampled at N means job_fetch_request=0 from N+1.
- Last handshake at cycle N gives compute_en=0 and job_complete=1 at N+1.
- job_complete_ack sampled at N means job_complete=0 at N+1, and a new job_start is accepted from N+1.
- job_fetch_ack and job_fetch_complete high in the same FETCH_REQ cycle: only the ack is used. job_fetch_complete must be seen again in FETCH.
- Minimum job length with 1x1x1 dims and immediate host responses: start→accept 1 cycle, then 1 cycle per state.

## Test plan
- 2x2x1 job, immediate acks: accept at N+1, fetch request until ack. Four handshakes report (row,col) = (0,0), (0,1), (1,0), (1,1). job_complete rises the cycle after the 4th and clears the cycle after job_complete_ack.
- Backpressure, 1x3x2 job: result_valid held with result_accept toggled 1,0,1,0… The counters advance only on accepted cycles; depth increments after col=2; completion after 6 handshakes.
- job_start and job_parameters_valid in the same cycle with rows=cols=depth=1: PARAM is skipped, params latch the same cycle, and completion follows a single handshake.
- Zero-dimension job (depth=0): after job_fetch_complete, DONE is entered directly. compute_en never rises and output_* stay 0.
- rst_n=0 during RUN after 3 of 4 results: every output is 0 the next cycle. A following job_start is accepted normally with counters starting at (0,0,0).
- Handshake in IDLE: err_unexpected_result=1 and stays set; the next accepted job_start clears it; counters are unchanged.
